id_inflight_tracker: RTL

- Integer-to-one-hot side of the ID path: converts integer IDs into one-hot form and tracks which IDs are in flight.
- Accepts integer ID issue and retire events from the issue and writeback logic.
- Maintains a registered one-hot in-flight mask, an occupancy count and full/empty flags.
- Emits registered one-hot decode pulses, used as write enables for per-ID tables.

---
 rtl/id_inflight_tracker_pkg.sv | 24 ++
 rtl/integer_to_one_hot.sv | 19 +
 rtl/id_inflight_tracker.sv | 93 +++++++++
 3 files changed

// File: rtl/id_inflight_tracker_pkg.sv
// Shared helpers for the ID in-flight tracker: derived widths and counter arithmetic.
package id_inflight_tracker_pkg;

    // Integer ID width for a table of n entries; a single-entry table still needs one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Net occupancy change for one cycle; retire and issue may both land together.
    function automatic int unsigned step_count(input int unsigned cnt,
                                               input logic        inc,
                                               input logic        dec);
        int unsigned nxt;
        nxt = cnt;
        if (inc) nxt = nxt + 1;
        if (dec) nxt = nxt - 1;
        return nxt;
    endfunction

endpackage

// File: rtl/integer_to_one_hot.sv
// Combinational integer-to-one-hot decoder; codes >= C_WIDTH decode to all-zero.
module integer_to_one_hot
    import id_inflight_tracker_pkg::*;
#(
    parameter  int C_WIDTH = 8,
    localparam int IN_W    = id_width(C_WIDTH)
) (
    input  logic [IN_W-1:0]    int_in,
    output logic [C_WIDTH-1:0] one_hot
);

    always_comb begin
        one_hot = '0;
        for (int i = 0; i < C_WIDTH; i++) begin
            if (int_in == IN_W'(i)) one_hot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/id_inflight_tracker.sv
// Tracks which integer IDs are in flight as a one-hot mask, with occupancy count,
// full/empty flags, one-cycle issue/retire decode pulses and a sticky error flag.
module id_inflight_tracker
    import id_inflight_tracker_pkg::*;
#(
    parameter  int NUM_IDS = 8,
    localparam int ID_W    = id_width(NUM_IDS),
    localparam int CNT_W   = cnt_width(NUM_IDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               issue_valid,
    input  logic [ID_W-1:0]    issue_id,
    input  logic               retire_valid,
    input  logic [ID_W-1:0]    retire_id,
    output logic [NUM_IDS-1:0] inflight,
    output logic [NUM_IDS-1:0] issue_onehot,
    output logic [NUM_IDS-1:0] retire_onehot,
    output logic [CNT_W-1:0]   inflight_count,
    output logic               full,
    output logic               empty,
    output logic               error
);

    logic [NUM_IDS-1:0] issue_dec;
    logic [NUM_IDS-1:0] retire_dec;
    logic [NUM_IDS-1:0] mask_after_retire;
    logic [NUM_IDS-1:0] inflight_d;
    logic [NUM_IDS-1:0] issue_pulse_d;
    logic [NUM_IDS-1:0] retire_pulse_d;
    logic [CNT_W-1:0]   count_d;
    logic               issue_ok;
    logic               retire_ok;
    logic               violation;

    integer_to_one_hot #(.C_WIDTH(NUM_IDS)) u_issue_dec (
        .int_in  (issue_id),
        .one_hot (issue_dec)
    );

    integer_to_one_hot #(.C_WIDTH(NUM_IDS)) u_retire_dec (
        .int_in  (retire_id),
        .one_hot (retire_dec)
    );

    // Out-of-range IDs decode to zero, so they can never match a set mask bit.
    // Retire is applied first so a same-cycle issue of the retiring ID is legal.
    always_comb begin
        retire_ok         = retire_valid && ((retire_dec & inflight) != '0);
        mask_after_retire = retire_ok ? (inflight & ~retire_dec) : inflight;
        issue_ok          = issue_valid && (issue_dec != '0)
                            && ((issue_dec & mask_after_retire) == '0);
        inflight_d        = issue_ok ? (mask_after_retire | issue_dec) : mask_after_retire;
        issue_pulse_d     = issue_ok  ? issue_dec  : '0;
        retire_pulse_d    = retire_ok ? retire_dec : '0;
        violation         = (issue_valid && !issue_ok) || (retire_valid && !retire_ok);
        count_d           = CNT_W'(step_count(32'(inflight_count), issue_ok, retire_ok));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight       <= '0;
            issue_onehot   <= '0;
            retire_onehot  <= '0;
            inflight_count <= '0;
            error          <= 1'b0;
        end else if (clear) begin
            inflight       <= '0;
            issue_onehot   <= '0;
            retire_onehot  <= '0;
            inflight_count <= '0;
            error          <= 1'b0;
        end else begin
            inflight       <= inflight_d;
            issue_onehot   <= issue_pulse_d;
            retire_onehot  <= retire_pulse_d;
            inflight_count <= count_d;
            error          <= error | violation;
        end
    end

    assign full  = (inflight_count == CNT_W'(NUM_IDS));
    assign empty = (inflight_count == '0);

    a_issue_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(issue_onehot));
    a_retire_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(retire_onehot));
    a_count_matches_mask: assert property (@(posedge clk) disable iff (!rst_n)
        32'(inflight_count) == $countones(inflight));

endmodule
